// File: rtl/stream_reg_slice_pkg.sv
// Shared types and helpers for the stream register slice.
// Stage modes and per-stage capacity.
package stream_reg_slice_pkg;

   typedef enum int unsigned {
      RS_LITE = 0,
      RS_FWD  = 1,
      RS_FULL = 2
   } rs_mode_e;

   function automatic int unsigned rs_capacity(int unsigned mode);
      return (mode == RS_FULL) ? 32'd2 : 32'd1;
   endfunction

endpackage

// File: rtl/stream_reg_slice_stage.sv
// One AXI4-Stream register stage: LITE (half rate), FWD (registered forward path)
// or FULL (main + skid register, every output registered).
module stream_reg_slice_stage
   import stream_reg_slice_pkg::*;
#(
   parameter int unsigned DW   = 32,
   parameter int unsigned UW   = 1,
   parameter int unsigned MODE = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] s_tdata,
   input  logic [UW-1:0] s_tuser,
   input  logic          s_tlast,
   input  logic          s_tvalid,
   output logic          s_tready,
   output logic [DW-1:0] m_tdata,
   output logic [UW-1:0] m_tuser,
   output logic          m_tlast,
   output logic          m_tvalid,
   input  logic          m_tready,
   output logic [1:0]    count
);

   localparam int unsigned PW = DW + UW + 1;

   logic [PW-1:0] s_pay;
   logic [PW-1:0] main_q;
   logic [PW-1:0] skid_q;
   logic          main_valid_q;
   logic          skid_valid_q;
   logic          in_hs;
   logic          out_hs;

   assign s_pay                        = {s_tlast, s_tuser, s_tdata};
   assign {m_tlast, m_tuser, m_tdata}  = main_q;
   assign m_tvalid                     = main_valid_q;
   assign in_hs                        = s_tvalid & s_tready;
   assign out_hs                       = main_valid_q & m_tready;
   assign count                        = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

   if (MODE == RS_FWD) begin : g_ready_fwd
      assign s_tready = !main_valid_q | m_tready;
   end else if (MODE == RS_FULL) begin : g_ready_full
      assign s_tready = !skid_valid_q;
   end else begin : g_ready_lite
      assign s_tready = !main_valid_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_q       <= '0;
         skid_q       <= '0;
      end else if (MODE == RS_FULL) begin
         if (skid_valid_q) begin
            // Full: no input accepted; drain skid into main as main leaves.
            if (out_hs) begin
               main_q       <= skid_q;
               skid_valid_q <= 1'b0;
            end
         end else if (main_valid_q) begin
            if (in_hs && m_tready) begin
               main_q <= s_pay;
            end else if (in_hs) begin
               skid_q       <= s_pay;
               skid_valid_q <= 1'b1;
            end else if (out_hs) begin
               main_valid_q <= 1'b0;
            end
         end else if (in_hs) begin
            main_q       <= s_pay;
            main_valid_q <= 1'b1;
         end
      end else begin
         // LITE never sees in_hs and out_hs together since ready = !valid.
         if (in_hs) begin
            main_q       <= s_pay;
            main_valid_q <= 1'b1;
         end else if (out_hs) begin
            main_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/stream_reg_slice.sv
// Parametrised AXI4-Stream register slice: STAGES cascaded stages of one MODE,
// with total held-beat occupancy.
module stream_reg_slice
   import stream_reg_slice_pkg::*;
#(
   parameter int unsigned DW     = 32,
   parameter int unsigned UW     = 1,
   parameter int unsigned MODE   = 2,
   parameter int unsigned STAGES = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DW-1:0]                    s_axis_tdata,
   input  logic [UW-1:0]                    s_axis_tuser,
   input  logic                             s_axis_tlast,
   input  logic                             s_axis_tvalid,
   output logic                             s_axis_tready,
   output logic [DW-1:0]                    m_axis_tdata,
   output logic [UW-1:0]                    m_axis_tuser,
   output logic                             m_axis_tlast,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic [$clog2(2*STAGES+1)-1:0]    occupancy
);

   localparam int unsigned OW = $clog2(2*STAGES+1);

   if (MODE > 32'd2 || STAGES == 0) begin : g_bad_cfg
      $fatal(1, "stream_reg_slice: illegal MODE or STAGES");
   end

   // Link k is the s side of stage k; link STAGES is the top-level m side.
   logic [DW-1:0] l_data  [STAGES+1];
   logic [UW-1:0] l_user  [STAGES+1];
   logic          l_last  [STAGES+1];
   logic          l_valid [STAGES+1];
   logic          l_ready [STAGES+1];
   logic [1:0]    cnt     [STAGES];

   assign l_data[0]       = s_axis_tdata;
   assign l_user[0]       = s_axis_tuser;
   assign l_last[0]       = s_axis_tlast;
   assign l_valid[0]      = s_axis_tvalid;
   assign s_axis_tready   = l_ready[0];
   assign m_axis_tdata    = l_data[STAGES];
   assign m_axis_tuser    = l_user[STAGES];
   assign m_axis_tlast    = l_last[STAGES];
   assign m_axis_tvalid   = l_valid[STAGES];
   assign l_ready[STAGES] = m_axis_tready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stream_reg_slice_stage #(
         .DW   (DW),
         .UW   (UW),
         .MODE (MODE)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .s_tdata  (l_data[k]),
         .s_tuser  (l_user[k]),
         .s_tlast  (l_last[k]),
         .s_tvalid (l_valid[k]),
         .s_tready (l_ready[k]),
         .m_tdata  (l_data[k+1]),
         .m_tuser  (l_user[k+1]),
         .m_tlast  (l_last[k+1]),
         .m_tvalid (l_valid[k+1]),
         .m_tready (l_ready[k+1]),
         .count    (cnt[k])
      );
   end

   always_comb begin
      occupancy = '0;
      for (int k = 0; k < STAGES; k++) begin
         occupancy = occupancy + OW'(cnt[k]);
      end
   end

endmodule
